y86_execute_stage: RTL and testbench
====================================

// Module: y86_execute_stage
// PURPOSE
//   Registered, parametrised Y86 execute stage for the PIPE core; successor to the combinational SEQ execute.
//   Computes valE, evaluates cnd against a stage-owned condition-code register, and resolves cmovXX destinations.
//   Holds one E->M entry behind a valid/ready handshake; supports flush and exception-driven CC freeze.
// PARAMETERS
//   WIDTH     64      datapath width (power of two, >=16); push/pop step = WIDTH/8
//   CC_RESET  3'b100  reset value of {ZF,SF,OF}
//   EXT_OPS   0       1: OPq ifun 4=OR, 5=SHL, 6=SAR additionally legal
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      decode stage presents an instruction
//   in_ready   out  1      stage can accept this cycle
//   icode      in   4      instruction code
//   ifun       in   4      function code
//   valA       in   WIDTH  operand A from decode
//   valB       in   WIDTH  operand B from decode
//   valC       in   WIDTH  immediate / displacement
//   dstE_in    in   4      E destination register (4'hF = none)
//   dstM_in    in   4      M destination register
//   stat_in    in   3      status (1=AOK, 2=HLT, 3=ADR, 4=INS)
//   flush      in   1      discard held entry and this cycle's accept
//   cc_freeze  in   1      later stage holds an exception; inhibit CC writes
//   out_valid  out  1      E->M entry valid
//   out_ready  in   1      memory stage accepts entry
//   out_icode  out  4      registered icode
//   out_valE   out  WIDTH  ALU result
//   out_valA   out  WIDTH  valA passed through
//   out_cnd    out  1      condition result
//   out_dstE   out  4      resolved E destination
//   out_dstM   out  4      dstM passed through
//   out_stat   out  3      status, possibly upgraded to INS
//   cc_out     out  3      current {ZF,SF,OF}
// BEHAVIOUR
//   Reset: out_valid=0; out_valE/out_valA/out_icode/out_cnd=0; out_dstE=out_dstM=4'hF; out_stat=1; CC=CC_RESET.
//   in_ready = !out_valid | out_ready (combinational). accept = in_valid & in_ready & !flush.
//   Latency 1 cycle: accepted instruction appears on out_* on the next edge.
//   out_valid next = accept | (out_valid & !out_ready & !flush).
//   Outputs are held stable while out_valid & !out_ready.
//   Flush: out_valid<=0 next edge; any same-cycle accept is dropped; no CC update.
//   ALU by icode:
//     2 cmov:        valE = valA
//     3 irmovq:      valE = valC
//     4/5 rm/mrmovq: valE = valB + valC
//     6 OPq:         valE = valB op valA (0 add, 1 sub B-A, 2 and, 3 xor)
//     8/A call/push: valE = valB - WIDTH/8
//     9/B ret/pop:   valE = valB + WIDTH/8
//     other icodes:  valE = 0
//   All arithmetic is mod 2^WIDTH.
//   OF rules:
//     add: signs of A and B equal and result sign differs.
//     sub: signs of A and B differ and result sign != sign of B.
//     logic/shift: OF=0.
//   EXT_OPS=1 only:
//     ifun 4 OR.
//     ifun 5 SHL by valA[log2(WIDTH)-1:0].
//     ifun 6 arithmetic right shift by the same amount.
//   OPq with illegal ifun: out_stat=4 (INS), valE=0, CC unchanged.
//   CC write on accept iff icode==6, ifun legal, stat_in==1, !cc_freeze.
//   CC write: ZF=(valE==0), SF=valE[WIDTH-1].
//   cnd is evaluated combinationally from CC *before* this instruction's own update:
//     0 always, 1 le (SF^OF)|ZF, 2 l SF^OF, 3 e ZF, 4 ne !ZF,
//     5 ge !(SF^OF), 6 g !(SF^OF)&!ZF, 7-F cnd=0.
//   cnd applies to icode 2 and 7; out_cnd=0 for all other icodes.
//   icode 2 with cnd=0: out_dstE=4'hF; otherwise out_dstE=dstE_in.
//   Reset mid-transfer: outputs and CC return to reset values immediately; the entry is lost.
//   Back-to-back OPq: the second instruction's cnd sees CC already written by the first (the first edge precedes the second accept).
// TESTING
//   Reset: rst_n=0 mid-cycle -> out_valid=0, cc_out=3'b100, out_dstE=F immediately.
//   OPq add, WIDTH=64: valB=7FFF_FFFF_FFFF_FFFF, valA=1 -> valE=8000_0000_0000_0000, next cc_out={0,1,1}.
//   OPq sub, valB=5, valA=5 -> valE=0, cc_out=100; then cmovne (2,4) dstE_in=3 -> out_cnd=0, out_dstE=F.
//   out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* held, no second accept, CC unchanged.
//   cc_freeze=1 during OPq xor valA=valB=9 -> valE=0, cc_out unchanged; flush same cycle as accept -> out_valid=0.
//   pushq valB=0x100 -> valE=0xF8; EXT_OPS=0 OPq ifun=5 -> out_stat=4; EXT_OPS=1 SAR 0x8000..0 by 63 -> all ones.

Source files
------------

// File: rtl/y86_execute_stage.sv
// y86_execute_stage
//   Registered execute stage for the pipelined Y86 core. It computes valE,
//   evaluates the branch/cmov condition against a condition-code register
//   owned by this stage, and resolves the cmovXX destination register. One
//   E->M entry is held behind a valid/ready handshake. Flush discards the
//   held entry and any same-cycle accept. cc_freeze stops CC writes while a
//   later stage holds an exception.
// Ports
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   : handshake with decode
//   icode, ifun           : instruction and function codes
//   valA, valB, valC      : operands and immediate
//   dstE_in, dstM_in      : destination registers (4'hF = none)
//   stat_in               : status (1=AOK, 2=HLT, 3=ADR, 4=INS)
//   flush, cc_freeze      : pipeline control
//   out_valid / out_ready : handshake with memory
//   out_*                 : registered E->M entry
//   cc_out                : current {ZF,SF,OF}
module y86_execute_stage #(
  parameter int            WIDTH    = 64,
  parameter logic [2:0]    CC_RESET = 3'b100,
  parameter int            EXT_OPS  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valB,
  input  logic [WIDTH-1:0] valC,
  input  logic [3:0]       dstE_in,
  input  logic [3:0]       dstM_in,
  input  logic [2:0]       stat_in,
  input  logic             flush,
  input  logic             cc_freeze,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_icode,
  output logic [WIDTH-1:0] out_valE,
  output logic [WIDTH-1:0] out_valA,
  output logic             out_cnd,
  output logic [3:0]       out_dstE,
  output logic [3:0]       out_dstM,
  output logic [2:0]       out_stat,
  output logic [2:0]       cc_out
);

  localparam int              SHW  = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] STEP = WIDTH'(WIDTH / 8);

  logic             accept_s;
  logic             legal_s;
  logic             cc_we_s;
  logic             cnd_s;
  logic             of_s;
  logic [WIDTH-1:0] alu_val_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic [SHW-1:0]   shamt_s;
  logic [3:0]       dste_s;
  logic [2:0]       stat_s;
  logic             zf_s;
  logic             sf_s;

  logic             out_valid_r;
  logic [3:0]       out_icode_r;
  logic [WIDTH-1:0] out_vale_r;
  logic [WIDTH-1:0] out_vala_r;
  logic             out_cnd_r;
  logic [3:0]       out_dste_r;
  logic [3:0]       out_dstm_r;
  logic [2:0]       out_stat_r;
  logic [2:0]       cc_r;

  assign in_ready = ~out_valid_r | out_ready;
  assign accept_s = in_valid & in_ready & ~flush;
  assign sum_s    = valB + valA;
  assign diff_s   = valB - valA;
  assign shamt_s  = valA[SHW-1:0];

  // Decide whether an OPq function code is implemented in this configuration.
  always_comb begin
    legal_s = 1'b0;
    if (icode == 4'h6) begin
      if (ifun <= 4'h3) begin
        legal_s = 1'b1;
      end else if ((EXT_OPS != 0) && (ifun <= 4'h6)) begin
        legal_s = 1'b1;
      end else begin
        legal_s = 1'b0;
      end
    end else begin
      legal_s = 1'b1;
    end
  end

  // ALU: result by icode/ifun plus the overflow flag for arithmetic OPq.
  always_comb begin
    alu_val_s = '0;
    of_s      = 1'b0;
    case (icode)
      4'h2: alu_val_s = valA;
      4'h3: alu_val_s = valC;
      4'h4, 4'h5: alu_val_s = valB + valC;
      4'h6: begin
        case (ifun)
          4'h0: begin
            alu_val_s = sum_s;
            of_s = (valA[WIDTH-1] == valB[WIDTH-1]) && (sum_s[WIDTH-1] != valB[WIDTH-1]);
          end
          4'h1: begin
            alu_val_s = diff_s;
            of_s = (valA[WIDTH-1] != valB[WIDTH-1]) && (diff_s[WIDTH-1] != valB[WIDTH-1]);
          end
          4'h2: alu_val_s = valB & valA;
          4'h3: alu_val_s = valB ^ valA;
          4'h4: alu_val_s = legal_s ? (valB | valA) : '0;
          4'h5: alu_val_s = legal_s ? (valB << shamt_s) : '0;
          4'h6: alu_val_s = legal_s ? WIDTH'($signed(valB) >>> shamt_s) : '0;
          default: alu_val_s = '0;
        endcase
      end
      4'h8, 4'hA: alu_val_s = valB - STEP;
      4'h9, 4'hB: alu_val_s = valB + STEP;
      default: alu_val_s = '0;
    endcase
  end

  assign zf_s = (alu_val_s == '0);
  assign sf_s = alu_val_s[WIDTH-1];

  // Condition from the CC value held before this instruction's own update.
  always_comb begin
    cnd_s = 1'b0;
    case (ifun)
      4'h0: cnd_s = 1'b1;
      4'h1: cnd_s = (cc_r[1] ^ cc_r[0]) | cc_r[2];
      4'h2: cnd_s = cc_r[1] ^ cc_r[0];
      4'h3: cnd_s = cc_r[2];
      4'h4: cnd_s = ~cc_r[2];
      4'h5: cnd_s = ~(cc_r[1] ^ cc_r[0]);
      4'h6: cnd_s = ~(cc_r[1] ^ cc_r[0]) & ~cc_r[2];
      default: cnd_s = 1'b0;
    endcase
  end

  // Destination and status resolution; a not-taken cmov writes no register.
  always_comb begin
    dste_s = dstE_in;
    stat_s = stat_in;
    if ((icode == 4'h2) && !cnd_s) begin
      dste_s = 4'hF;
    end else begin
      dste_s = dstE_in;
    end
    if (!legal_s) begin
      stat_s = 3'd4;
    end else begin
      stat_s = stat_in;
    end
  end

  assign cc_we_s = accept_s && (icode == 4'h6) && legal_s && (stat_in == 3'd1) && !cc_freeze;

  // E->M entry register; held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_icode_r <= 4'h0;
      out_vale_r  <= '0;
      out_vala_r  <= '0;
      out_cnd_r   <= 1'b0;
      out_dste_r  <= 4'hF;
      out_dstm_r  <= 4'hF;
      out_stat_r  <= 3'd1;
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_icode_r <= icode;
      out_vale_r  <= alu_val_s;
      out_vala_r  <= valA;
      out_cnd_r   <= ((icode == 4'h2) || (icode == 4'h7)) ? cnd_s : 1'b0;
      out_dste_r  <= dste_s;
      out_dstm_r  <= dstM_in;
      out_stat_r  <= stat_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Condition-code register, written only by accepted legal AOK OPq.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_r <= CC_RESET;
    end else if (cc_we_s) begin
      cc_r <= {zf_s, sf_s, of_s};
    end
  end

  assign out_valid = out_valid_r;
  assign out_icode = out_icode_r;
  assign out_valE  = out_vale_r;
  assign out_valA  = out_vala_r;
  assign out_cnd   = out_cnd_r;
  assign out_dstE  = out_dste_r;
  assign out_dstM  = out_dstm_r;
  assign out_stat  = out_stat_r;
  assign cc_out    = cc_r;

endmodule

// File: tb/tb_y86_execute_stage.sv
module tb_y86_execute_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] valC;
  logic [3:0]  dstE_in;
  logic [3:0]  dstM_in;
  logic [2:0]  stat_in;
  logic        flush;
  logic        cc_freeze;
  logic        out_ready;

  // Instance a: EXT_OPS=0
  logic        a_in_ready, a_out_valid, a_out_cnd;
  logic [3:0]  a_out_icode, a_out_dstE, a_out_dstM;
  logic [63:0] a_out_valE, a_out_valA;
  logic [2:0]  a_out_stat, a_cc_out;
  // Instance b: EXT_OPS=1
  logic        b_in_ready, b_out_valid, b_out_cnd;
  logic [3:0]  b_out_icode, b_out_dstE, b_out_dstM;
  logic [63:0] b_out_valE, b_out_valA;
  logic [2:0]  b_out_stat, b_cc_out;

  int tests;
  int fails;

  y86_execute_stage #(.WIDTH(64), .CC_RESET(3'b100), .EXT_OPS(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
    .dstE_in(dstE_in), .dstM_in(dstM_in), .stat_in(stat_in),
    .flush(flush), .cc_freeze(cc_freeze),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_icode(a_out_icode),
    .out_valE(a_out_valE), .out_valA(a_out_valA), .out_cnd(a_out_cnd),
    .out_dstE(a_out_dstE), .out_dstM(a_out_dstM), .out_stat(a_out_stat),
    .cc_out(a_cc_out));

  y86_execute_stage #(.WIDTH(64), .CC_RESET(3'b100), .EXT_OPS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
    .dstE_in(dstE_in), .dstM_in(dstM_in), .stat_in(stat_in),
    .flush(flush), .cc_freeze(cc_freeze),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_icode(b_out_icode),
    .out_valE(b_out_valE), .out_valA(b_out_valA), .out_cnd(b_out_cnd),
    .out_dstE(b_out_dstE), .out_dstM(b_out_dstM), .out_stat(b_out_stat),
    .cc_out(b_cc_out));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] c, input logic [3:0] de);
    in_valid = 1'b1;
    icode    = ic;
    ifun     = fn;
    valA     = a;
    valB     = b;
    valC     = c;
    dstE_in  = de;
    dstM_in  = 4'hF;
    stat_in  = 3'd1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; in_valid = 1'b0; icode = 4'h0; ifun = 4'h0;
    valA = 64'h0; valB = 64'h0; valC = 64'h0; dstE_in = 4'hF; dstM_in = 4'hF;
    stat_in = 3'd1; flush = 1'b0; cc_freeze = 1'b0; out_ready = 1'b1;
    #12;
    check("rst_valid", {63'h0, a_out_valid}, 64'h0);
    check("rst_cc", {61'h0, a_cc_out}, 64'h4);
    check("rst_dstE", {60'h0, a_out_dstE}, 64'hF);
    check("rst_stat", {61'h0, a_out_stat}, 64'h1);
    check("rst_valE", a_out_valE, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // OPq add with signed overflow
    drive(4'h6, 4'h0, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 4'h3);
    tick();
    check("add_valid", {63'h0, a_out_valid}, 64'h1);
    check("add_valE", a_out_valE, 64'h8000_0000_0000_0000);
    check("add_cc", {61'h0, a_cc_out}, 64'h3);
    check("add_dstE", {60'h0, a_out_dstE}, 64'h3);
    check("add_cnd", {63'h0, a_out_cnd}, 64'h0);

    // OPq sub to zero
    drive(4'h6, 4'h1, 64'h5, 64'h5, 64'h0, 4'h3);
    tick();
    check("sub_valE", a_out_valE, 64'h0);
    check("sub_cc", {61'h0, a_cc_out}, 64'h4);

    // cmovne not taken (ZF=1)
    drive(4'h2, 4'h4, 64'h55, 64'h0, 64'h0, 4'h3);
    tick();
    check("cmovne_cnd", {63'h0, a_out_cnd}, 64'h0);
    check("cmovne_dstE", {60'h0, a_out_dstE}, 64'hF);
    check("cmovne_valE", a_out_valE, 64'h55);

    // cmove taken
    drive(4'h2, 4'h3, 64'h66, 64'h0, 64'h0, 4'h3);
    tick();
    check("cmove_cnd", {63'h0, a_out_cnd}, 64'h1);
    check("cmove_dstE", {60'h0, a_out_dstE}, 64'h3);

    // Back-pressure: consumer stalls 3 cycles with a new instruction waiting
    out_ready = 1'b0;
    drive(4'h3, 4'h0, 64'h0, 64'h0, 64'h1234, 4'h5);
    #1;
    check("bp_in_ready", {63'h0, a_in_ready}, 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid", {63'h0, a_out_valid}, 64'h1);
      check("bp_valE_hold", a_out_valE, 64'h66);
      check("bp_dstE_hold", {60'h0, a_out_dstE}, 64'h3);
      check("bp_cc", {61'h0, a_cc_out}, 64'h4);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {63'h0, a_in_ready}, 64'h1);
    tick();
    check("irmov_valE", a_out_valE, 64'h1234);
    check("irmov_dstE", {60'h0, a_out_dstE}, 64'h5);

    // add 1+2 -> CC all clear
    drive(4'h6, 4'h0, 64'h2, 64'h1, 64'h0, 4'h4);
    tick();
    check("add3_valE", a_out_valE, 64'h3);
    check("add3_cc", {61'h0, a_cc_out}, 64'h0);

    // xor to zero under cc_freeze: CC must not become 100
    cc_freeze = 1'b1;
    drive(4'h6, 4'h3, 64'h9, 64'h9, 64'h0, 4'h4);
    tick();
    cc_freeze = 1'b0;
    check("frz_valE", a_out_valE, 64'h0);
    check("frz_cc", {61'h0, a_cc_out}, 64'h0);

    // flush in the accept cycle drops the instruction and its CC update
    flush = 1'b1;
    drive(4'h6, 4'h1, 64'h2, 64'h1, 64'h0, 4'h4);
    tick();
    flush = 1'b0;
    check("flush_valid", {63'h0, a_out_valid}, 64'h0);
    check("flush_cc", {61'h0, a_cc_out}, 64'h0);

    // pushq / popq / mrmovq address arithmetic
    drive(4'hA, 4'h0, 64'h0, 64'h100, 64'h0, 4'h4);
    tick();
    check("push_valE", a_out_valE, 64'hF8);
    drive(4'hB, 4'h0, 64'h0, 64'h100, 64'h0, 4'h4);
    tick();
    check("pop_valE", a_out_valE, 64'h108);
    drive(4'h5, 4'h0, 64'h0, 64'h10, 64'h8, 4'hF);
    tick();
    check("mrmov_valE", a_out_valE, 64'h18);

    // ifun 5 (SHL): illegal without EXT_OPS, legal with
    drive(4'h6, 4'h5, 64'd63, 64'h8000_0000_0000_0000, 64'h0, 4'h4);
    tick();
    check("a_shl_stat", {61'h0, a_out_stat}, 64'h4);
    check("a_shl_valE", a_out_valE, 64'h0);
    check("a_shl_cc", {61'h0, a_cc_out}, 64'h0);
    check("b_shl_stat", {61'h0, b_out_stat}, 64'h1);
    check("b_shl_valE", b_out_valE, 64'h0);
    check("b_shl_cc", {61'h0, b_cc_out}, 64'h4);

    // ifun 6 (SAR) by 63
    drive(4'h6, 4'h6, 64'd63, 64'h8000_0000_0000_0000, 64'h0, 4'h4);
    tick();
    check("a_sar_stat", {61'h0, a_out_stat}, 64'h4);
    check("b_sar_valE", b_out_valE, 64'hFFFF_FFFF_FFFF_FFFF);
    check("b_sar_cc", {61'h0, b_cc_out}, 64'h2);

    // jl: CC a=000 -> not taken, CC b=010 -> taken
    drive(4'h7, 4'h2, 64'h0, 64'h0, 64'h40, 4'hF);
    tick();
    check("a_jl_cnd", {63'h0, a_out_cnd}, 64'h0);
    check("b_jl_cnd", {63'h0, b_out_cnd}, 64'h1);

    // nop-like icode gives valE=0 and no cnd
    drive(4'h1, 4'h0, 64'h7, 64'h7, 64'h7, 4'hF);
    tick();
    check("nop_valE", a_out_valE, 64'h0);

    // drain
    in_valid = 1'b0;
    tick();
    check("drain_valid", {63'h0, a_out_valid}, 64'h0);

    // reset asserted mid-cycle with an entry held
    drive(4'h6, 4'h0, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 4'h3);
    tick();
    in_valid = 1'b0;
    check("pre_rst_valid", {63'h0, a_out_valid}, 64'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {63'h0, a_out_valid}, 64'h0);
    check("mid_rst_cc", {61'h0, a_cc_out}, 64'h4);
    check("mid_rst_dstE", {60'h0, a_out_dstE}, 64'hF);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
